// File: rtl/j17_mc_datapath.sv
// Multi-cycle J17 datapath: issues one decoded instruction at a time and runs it
// through EXEC, an optional memory handshake and a write-back cycle.
module j17_mc_datapath #(
  parameter int WIDTH  = 32,
  parameter int NREGS  = 32,
  parameter int IMM_W  = 16,
  parameter int ADDR_W = 10,
  localparam int RAW   = $clog2(NREGS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [4:0]        alucode,
  input  logic [RAW-1:0]    op0,
  input  logic [RAW-1:0]    op1,
  input  logic [RAW-1:0]    op2,
  input  logic [IMM_W-1:0]  imm,
  input  logic              imControl,
  input  logic              regenable,
  input  logic [1:0]        ramenable,
  input  logic [2:0]        pcControl,
  input  logic [1:0]        writecode,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  output logic [WIDTH-1:0]  PC,
  output logic              done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_MEM  = 2'd2;
  localparam logic [1:0] S_WB   = 2'd3;

  logic [1:0]       state;
  logic [WIDTH-1:0] regs [NREGS];

  logic [4:0]       alu_q;
  logic [RAW-1:0]   dst_q;
  logic [IMM_W-1:0] imm_q;
  logic             regen_q;
  logic [1:0]       ram_q;
  logic [2:0]       pcc_q;
  logic [1:0]       wc_q;
  logic [WIDTH-1:0] num1_q, num2_q, sdata_q, alu_res_q, npc_q, load_q;

  logic [WIDTH-1:0] rd0, rd1, rd2, imm_x, imm_qx, alu_out, wb_val;
  logic             taken, is_mem;

  // Register 0 is hard-wired to zero on the read side.
  assign rd0    = (op0 == '0) ? '0 : regs[op0];
  assign rd1    = (op1 == '0) ? '0 : regs[op1];
  assign rd2    = (op2 == '0) ? '0 : regs[op2];
  assign imm_x  = {{(WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
  assign imm_qx = {{(WIDTH-IMM_W){imm_q[IMM_W-1]}}, imm_q};
  assign is_mem = (ram_q == 2'd1) || (ram_q == 2'd2);

  assign issue_ready = (state == S_IDLE) && !reset;
  assign done        = (state == S_WB);

  always_comb begin
    alu_out = '1;
    case (alu_q)
      5'd0:  alu_out = num1_q;
      5'd1:  alu_out = num1_q + num2_q;
      5'd2:  alu_out = num1_q - num2_q;
      5'd3:  alu_out = num1_q * num2_q;
      5'd4:  alu_out = (num2_q == '0) ? '1 : num1_q / num2_q;
      5'd5:  alu_out = (num2_q == '0) ? num1_q : num1_q % num2_q;
      5'd6:  alu_out = num1_q | num2_q;
      5'd7:  alu_out = num1_q & num2_q;
      5'd8:  alu_out = num1_q ^ num2_q;
      5'd9:  alu_out = ~num1_q;
      5'd10: alu_out = num1_q >> 1;
      5'd11: alu_out = num1_q << 1;
      default: alu_out = '1;
    endcase
  end

  always_comb begin
    taken = 1'b0;
    case (pcc_q)
      3'd1: taken = (num1_q == num2_q);
      3'd2: taken = (num1_q <  num2_q);
      3'd3: taken = (num1_q >  num2_q);
      3'd4: taken = (num1_q != num2_q);
      3'd5: taken = (num1_q <= num2_q);
      3'd6: taken = (num1_q >= num2_q);
      3'd7: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // Load data only counts for an actual load; otherwise the load source is zero.
  always_comb begin
    wb_val = '0;
    case (wc_q)
      2'd0: wb_val = alu_res_q;
      2'd1: wb_val = num2_q;
      2'd2: wb_val = (ram_q == 2'd1) ? load_q : '0;
      2'd3: wb_val = PC + WIDTH'(1);
      default: wb_val = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      alu_q     <= '0;
      dst_q     <= '0;
      imm_q     <= '0;
      regen_q   <= 1'b0;
      ram_q     <= '0;
      pcc_q     <= '0;
      wc_q      <= '0;
      num1_q    <= '0;
      num2_q    <= '0;
      sdata_q   <= '0;
      alu_res_q <= '0;
      npc_q     <= '0;
      load_q    <= '0;
      PC        <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue_valid) begin
            alu_q   <= alucode;
            dst_q   <= op0;
            imm_q   <= imm;
            regen_q <= regenable;
            ram_q   <= ramenable;
            pcc_q   <= pcControl;
            wc_q    <= writecode;
            num1_q  <= rd1;
            num2_q  <= imControl ? imm_x : rd2;
            sdata_q <= rd0;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_res_q <= alu_out;
          npc_q     <= taken ? (PC + imm_qx) : (PC + WIDTH'(1));
          if (is_mem) begin
            mem_req   <= 1'b1;
            mem_we    <= (ram_q == 2'd2);
            mem_addr  <= ADDR_W'(num1_q + imm_qx);
            mem_wdata <= sdata_q;
            state     <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (ram_q == 2'd1) load_q <= mem_rdata;
            state <= S_WB;
          end
        end
        default: begin
          PC    <= npc_q;
          state <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if ((state == S_WB) && regen_q && (dst_q != '0)) begin
      regs[dst_q] <= wb_val;
    end
  end

endmodule

// File: tb/tb_j17_mc_datapath.sv
// Directed self-checking bench for j17_mc_datapath: a small acking memory model
// plus a linear sequence of instructions with hand-computed results.
module tb_j17_mc_datapath;

  logic        clock = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  alucode;
  logic [4:0]  op0, op1, op2;
  logic [15:0] imm;
  logic        imControl, regenable;
  logic [1:0]  ramenable, writecode;
  logic [2:0]  pcControl;
  logic        mem_req, mem_we, mem_ack;
  logic [9:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata, PC;
  logic        done;

  int total = 0;
  int bad = 0;
  int ackDelay = 1;
  int reqCycles;
  int edgeCount = 0;
  int base;
  int doneEdge, doneAbs, reqCount, dones;
  logic        addrStable, gotDone, capWe;
  logic [9:0]  firstAddr;
  logic [31:0] capWdata;
  logic [31:0] ram [1024];

  j17_mc_datapath dut (
    .clock(clock), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .alucode(alucode), .op0(op0), .op1(op1), .op2(op2), .imm(imm),
    .imControl(imControl), .regenable(regenable), .ramenable(ramenable),
    .pcControl(pcControl), .writecode(writecode),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .PC(PC), .done(done)
  );

  always #5 clock = ~clock;

  always @(posedge clock) edgeCount <= edgeCount + 1;

  // Memory responder: raises ack after ackDelay cycles of an outstanding request.
  initial begin
    mem_ack = 1'b0;
    mem_rdata = '0;
    reqCycles = 0;
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    forever begin
      @(posedge clock);
      #1;
      if (mem_req) begin
        reqCycles++;
        mem_rdata = ram[mem_addr];
        if (reqCycles >= ackDelay) begin
          mem_ack = 1'b1;
          if (mem_we) ram[mem_addr] = mem_wdata;
        end else begin
          mem_ack = 1'b0;
        end
      end else begin
        reqCycles = 0;
        mem_ack = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("[TB] FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issues one instruction at a negedge and follows it until it retires.
  task automatic applyStimulus(input logic [4:0] alu, input logic [4:0] o0, input logic [4:0] o1,
                               input logic [4:0] o2, input logic [15:0] im, input logic ic,
                               input logic re, input logic [1:0] ram_en, input logic [2:0] pcc,
                               input logic [1:0] wc);
    alucode = alu; op0 = o0; op1 = o1; op2 = o2; imm = im;
    imControl = ic; regenable = re; ramenable = ram_en; pcControl = pcc; writecode = wc;
    issue_valid = 1'b1;
    @(negedge clock);
    issue_valid = 1'b0;
    doneEdge = 0; doneAbs = 0; reqCount = 0; addrStable = 1'b1; gotDone = 1'b0;
    for (int j = 1; j <= 40 && !gotDone; j++) begin
      @(negedge clock);
      if (mem_req) begin
        if (reqCount == 0) begin
          firstAddr = mem_addr; capWdata = mem_wdata; capWe = mem_we;
        end else if (mem_addr !== firstAddr || mem_wdata !== capWdata) begin
          addrStable = 1'b0;
        end
        reqCount++;
      end
      if (done) begin
        gotDone = 1'b1;
        doneEdge = j + 1;
        doneAbs = edgeCount - base;
      end
    end
    if (!gotDone) checkOutput("retire_timeout", 32'd0, 32'd1);
    @(negedge clock);
  endtask

  task automatic checkReg(input logic [4:0] r, input logic [31:0] exp, input string tag);
    ackDelay = 1;
    applyStimulus(5'd0, r, 5'd0, 5'd0, 16'd0, 1'b1, 1'b0, 2'd2, 3'd0, 2'd0);
    checkOutput(tag, capWdata, exp);
  endtask

  initial begin
    reset = 1'b1; issue_valid = 1'b0;
    alucode = '0; op0 = '0; op1 = '0; op2 = '0; imm = '0;
    imControl = 1'b0; regenable = 1'b0; ramenable = '0; pcControl = '0; writecode = '0;
    repeat (2) @(negedge clock);
    checkOutput("rst_pc", PC, 32'd0);
    checkOutput("rst_req", mem_req, 1'b0);
    checkOutput("rst_we", mem_we, 1'b0);
    checkOutput("rst_addr", mem_addr, 32'd0);
    checkOutput("rst_wdata", mem_wdata, 32'd0);
    checkOutput("rst_done", done, 1'b0);
    reset = 1'b0;
    base = edgeCount;
    #1;
    checkOutput("ready_after_rst", issue_ready, 1'b1);

    // Back-to-back adds: r1 = 5, r2 = r1 + r1
    applyStimulus(5'd1, 5'd1, 5'd0, 5'd0, 16'd5, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0);
    checkOutput("add1_done_cycle", doneAbs, 32'd2);
    checkOutput("done_pulse_len", done, 1'b0);
    checkOutput("ready_after_wb", issue_ready, 1'b1);
    applyStimulus(5'd1, 5'd2, 5'd1, 5'd1, 16'd0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0);
    checkOutput("add2_done_cycle", doneAbs, 32'd5);
    checkOutput("pc_after_adds", PC, 32'd2);
    checkReg(5'd1, 32'd5, "r1");
    checkReg(5'd2, 32'd10, "r2");

    // Branches: r3 = 7, r4 = 7, jump to 10, beq back by one
    applyStimulus(5'd1, 5'd3, 5'd0, 5'd0, 16'd7, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd1, 5'd4, 5'd0, 5'd0, 16'd7, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 16'd4, 1'b1, 1'b0, 2'd0, 3'd7, 2'd0);
    checkOutput("jmp_pc10", PC, 32'd10);
    applyStimulus(5'd0, 5'd0, 5'd3, 5'd4, 16'hFFFF, 1'b0, 1'b0, 2'd0, 3'd1, 2'd0);
    checkOutput("beq_taken", PC, 32'd9);
    applyStimulus(5'd1, 5'd4, 5'd0, 5'd0, 16'd8, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd3, 5'd4, 16'hFFFF, 1'b0, 1'b0, 2'd0, 3'd1, 2'd0);
    checkOutput("beq_not_taken", PC, 32'd11);
    applyStimulus(5'd0, 5'd0, 5'd3, 5'd4, 16'd3, 1'b0, 1'b0, 2'd0, 3'd2, 2'd0);
    checkOutput("blt_taken", PC, 32'd14);
    applyStimulus(5'd9, 5'd3, 5'd0, 5'd0, 16'd0, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd1, 5'd4, 5'd0, 5'd0, 16'd1, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd0, 5'd0, 5'd3, 5'd4, 16'd5, 1'b0, 1'b0, 2'd0, 3'd2, 2'd0);
    checkOutput("blt_unsigned", PC, 32'd17);
    applyStimulus(5'd0, 5'd0, 5'd3, 5'd4, 16'd3, 1'b0, 1'b0, 2'd0, 3'd3, 2'd0);
    checkOutput("bgt_taken", PC, 32'd20);

    // Build r1 = 0xDEADBEEF = sext(0xBEEF) - 0x2152 * 0x100 * 0x100
    applyStimulus(5'd1, 5'd7, 5'd0, 5'd0, 16'h2152, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd1, 5'd8, 5'd0, 5'd0, 16'h0100, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd3, 5'd8, 5'd8, 5'd8, 16'd0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd3, 5'd7, 5'd7, 5'd8, 16'd0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd1, 5'd1, 5'd0, 5'd0, 16'hBEEF, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd2, 5'd1, 5'd1, 5'd7, 16'd0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd3, 5'd9, 5'd8, 5'd8, 16'd0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0);
    checkReg(5'd9, 32'd0, "mul_overflow");
    checkReg(5'd7, 32'h21520000, "mul");

    // Store with three MEM cycles, then load back with immediate ack
    ackDelay = 3;
    applyStimulus(5'd0, 5'd1, 5'd0, 5'd0, 16'h03FF, 1'b1, 1'b0, 2'd2, 3'd0, 2'd0);
    checkOutput("st_req_cycles", reqCount, 32'd3);
    checkOutput("st_stable", addrStable, 1'b1);
    checkOutput("st_addr", firstAddr, 32'h3FF);
    checkOutput("st_we", capWe, 1'b1);
    checkOutput("st_wdata", capWdata, 32'hDEADBEEF);
    checkOutput("st_done_cycle", doneEdge, 32'd5);
    ackDelay = 1;
    applyStimulus(5'd0, 5'd5, 5'd0, 5'd0, 16'h03FF, 1'b1, 1'b1, 2'd1, 3'd0, 2'd2);
    checkOutput("ld_done_cycle", doneEdge, 32'd3);
    checkOutput("ld_we", capWe, 1'b0);
    checkReg(5'd5, 32'hDEADBEEF, "ld_r5");
    checkOutput("pc_after_mem", PC, 32'd32);

    // ALU corner cases with r10 = 9
    applyStimulus(5'd1, 5'd10, 5'd0, 5'd0, 16'd9, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd4, 5'd11, 5'd10, 5'd0, 16'd0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd5, 5'd12, 5'd10, 5'd0, 16'd0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd20, 5'd13, 5'd10, 5'd0, 16'd0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd10, 5'd14, 5'd11, 5'd0, 16'd0, 1'b0, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd1, 5'd0, 5'd0, 5'd0, 16'd5, 1'b1, 1'b1, 2'd0, 3'd0, 2'd0);
    applyStimulus(5'd1, 5'd15, 5'd0, 5'd0, 16'd3, 1'b1, 1'b1, 2'd0, 3'd0, 2'd2);
    checkReg(5'd11, 32'hFFFFFFFF, "div_by_zero");
    checkReg(5'd12, 32'd9, "mod_by_zero");
    checkReg(5'd13, 32'hFFFFFFFF, "bad_alucode");
    checkReg(5'd14, 32'h7FFFFFFF, "shr");
    checkReg(5'd0, 32'd0, "r0_zero");
    checkReg(5'd15, 32'd0, "wc2_nonload");
    checkOutput("pc_after_alu", PC, 32'd45);

    // Jump back to 4, then link to 0x24
    applyStimulus(5'd0, 5'd0, 5'd0, 5'd0, 16'hFFD7, 1'b1, 1'b0, 2'd0, 3'd7, 2'd0);
    checkOutput("jmp_pc4", PC, 32'd4);
    applyStimulus(5'd0, 5'd31, 5'd0, 5'd0, 16'h0020, 1'b1, 1'b1, 2'd0, 3'd7, 2'd3);
    checkOutput("link_pc", PC, 32'h24);
    checkReg(5'd31, 32'd5, "link_r31");

    // issue_valid held through EXEC must retire only once
    alucode = 5'd1; op0 = 5'd16; op1 = 5'd0; op2 = 5'd0; imm = 16'd1;
    imControl = 1'b1; regenable = 1'b1; ramenable = 2'd0; pcControl = 3'd0; writecode = 2'd0;
    issue_valid = 1'b1;
    dones = 0;
    @(negedge clock);
    @(negedge clock);
    issue_valid = 1'b0;
    for (int j = 0; j < 6; j++) begin
      if (done) dones++;
      @(negedge clock);
    end
    checkOutput("single_accept", dones, 32'd1);
    checkOutput("single_accept_pc", PC, 32'h26);

    // Reset in the second MEM cycle of a stalled store
    ackDelay = 10;
    alucode = 5'd0; op0 = 5'd1; imm = 16'd0; regenable = 1'b0; ramenable = 2'd2;
    issue_valid = 1'b1;
    @(negedge clock);
    @(negedge clock);
    checkOutput("abort_req_mem1", mem_req, 1'b1);
    @(negedge clock);
    reset = 1'b1;
    issue_valid = 1'b0;
    #1;
    checkOutput("abort_req_drop", mem_req, 1'b0);
    checkOutput("abort_pc", PC, 32'd0);
    checkOutput("abort_done", done, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checkOutput("abort_ready", issue_ready, 1'b1);
    dones = 0;
    for (int j = 0; j < 4; j++) begin
      @(negedge clock);
      if (done) dones++;
    end
    checkOutput("abort_no_done", dones, 32'd0);
    checkReg(5'd1, 32'd0, "abort_regs_cleared");

    $display("[TB] directed sequence complete");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/j17_mc_datapath.md
# j17_mc_datapath

Parametrised multi-cycle successor to the J17 single-cycle datapath. It accepts one decoded instruction at a time through a valid/ready issue handshake and executes it over several cycles. Execution uses an NREGS x WIDTH register file, a 12-operation ALU, a six-condition branch unit and an external memory port with a req/ack handshake. It sits between the J17 decoder and the data RAM, owns the PC, and adds reset, a zero register, load/store wait states and a link write-back.

## Interface
- WIDTH, 32, datapath, register and PC width
- NREGS, 32, register count (power of 2); RAW = clog2(NREGS)
- IMM_W, 16, immediate width, sign-extended to WIDTH
- ADDR_W, 10, memory address width
- clock  in  1  processor clock, rising edge
- reset  in  1  asynchronous, active-high
- issue_valid  in  1  decoded instruction present
- issue_ready  out  1  high only in IDLE
- alucode  in  5  ALU operation
- op0, op1, op2  in  RAW each  destination/store-data, source 1, source 2 register indices
- imm  in  IMM_W  immediate / branch offset / address offset
- imControl  in  1  1: num2 = sext(imm); 0: num2 = regs[op2]
- regenable  in  1  write back to regs[op0]
- ramenable  in  2  0 none, 1 load, 2 store, 3 treated as none
- pcControl  in  3  PC update mode
- writecode  in  2  write-back source: 0 ALU, 1 num2, 2 load data, 3 PC+1 (link)
- mem_req, mem_we  out  1 each  memory request, write strobe
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  WIDTH  store data
- mem_rdata  in  WIDTH  load data, valid with mem_ack
- mem_ack  in  1  completes the current request
- PC  out  WIDTH  program counter
- done  out  1  one-cycle retire pulse

## Operation
- States: IDLE -> EXEC -> (MEM if ramenable is 1 or 2) -> WB -> IDLE.
- IDLE: when issue_valid=1, latch all control fields plus num1=regs[op1], num2 and store data regs[op0]; go to EXEC. No issue_valid means stay in IDLE.
- EXEC: register the ALU result and the branch decision. Load/store goes to MEM; all other instructions go to WB.
- ALU (operates on num1 and num2, result mod 2^WIDTH):
  - 0 num1; 1 add; 2 sub; 3 mul (low WIDTH bits); 4 unsigned div; 5 unsigned mod
  - 6 or; 7 and; 8 xor; 9 ~num1; 10 num1>>1 (logical); 11 num1<<1
  - Any other code gives all-ones.
  - Divide by zero gives all-ones; mod by zero gives num1.
- Branch (compares num1 vs num2, unsigned):
  - 0: PC+1
  - 1 eq, 2 lt, 3 gt, 4 ne, 5 le, 6 ge: taken -> PC+sext(imm), else PC+1
  - 7: PC+sext(imm) unconditionally
  - PC wraps mod 2^WIDTH.
- MEM:
  - On entry, register mem_addr=(num1+sext(imm))[ADDR_W-1:0], mem_wdata=store data, mem_we=(ramenable==2), mem_req=1.
  - mem_req and all mem outputs are held stable until mem_ack is sampled high.
  - Loads capture mem_rdata on that edge. mem_req drops in the following cycle; go to WB.
- WB: done=1. If regenable=1 and op0!=0, regs[op0] is written from the writecode source. PC is updated. Both take effect at the end of the WB cycle.
- Register 0 reads as zero; writes to it are discarded.
- writecode=2 on a non-load writes an undefined-free zero.
- issue_valid while not in IDLE is ignored and not latched.

## Timing
- Reset values (asynchronous, immediate):
  - state IDLE, all registers 0, PC=0
  - done=0, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0
  - issue_ready=1 once reset is released
- Non-memory instruction: accepted at edge 0, EXEC at edge 1, WB cycle ends at edge 2 (done high during that cycle), issue_ready high in the next cycle. Throughput is 1 instruction per 3 cycles.
- Memory instruction: 3 + N cycles, where N≥1 is the number of MEM cycles up to and including the one in which mem_ack is sampled.
- mem_ack high in the first MEM cycle gives N=1. mem_ack outside MEM is ignored.
- Operands are sampled at issue, so back-to-back dependent instructions see the prior write-back and no hazard exists.
- When op1==op0, the instruction reads the old value.
- Reset asserted mid-instruction (including MEM with mem_req high) aborts immediately: mem_req drops asynchronously, and there is no write-back and no done pulse.

## Test plan
- Reset, then issue add r1 = r0 + imm 5 (imControl=1, writecode=0), then add r2 = r1 + r1 -> r1=5, r2=10, done pulses at cycles 2 and 5, PC=2.
- r3=7 and r4=7, issue pcControl=1 with imm=-1 from PC=10 -> PC=9. Repeat with r4=8 -> PC=11. pcControl=2 with r3=0xFFFFFFFF, r4=1 -> not taken (unsigned compare).
- Store r1=0xDEADBEEF to r0+imm 0x3FF with ack delayed 3 cycles -> mem_req high for exactly 3 cycles with address 0x3FF stable, done at cycle 5. Load back into r5 with immediate ack -> r5=0xDEADBEEF.
- ALU edge cases: div 9/0 -> 0xFFFFFFFF; mod 9%0 -> 9; mul 0x10000*0x10000 -> 0; alucode 20 -> 0xFFFFFFFF; write to r0 -> r0 still reads 0.
- Link: pcControl=7, imm=0x20, writecode=3, op0=31 from PC=4 -> r31=5, PC=0x24.
- Assert reset in the second MEM cycle of a store -> mem_req low immediately, PC=0, no done pulse, issue_ready=1 after release. issue_valid held high during EXEC is not double-accepted.
